// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle restoring divider for MIPS DIV/DIVU (HI/LO path).
// EX holds start_i high and stalls until ready_o; result_o = {remainder, quotient}.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   signed_div_i      1 = signed DIV, 0 = DIVU (sampled at start)
//   opdata1_i/2_i     dividend / divisor (sampled at start)
//   start_i           request, held until ready_o is seen
//   annul_i           abort in-flight operation (flush/exception)
//   result_o          {remainder[2W-1:W], quotient[W-1:0]}, registered
//   ready_o           result valid (state END)
// Optional: define DIV_EARLY_EXIT_EN to finish |dividend| < |divisor| in two cycles.
module mips_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

`ifdef DIV_EARLY_EXIT_EN
  typedef enum logic [2:0] {
    S_FREE = 3'd0, S_BYZERO = 3'd1, S_ON = 3'd2, S_END = 3'd3, S_EARLY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_FREE = 3'd0, S_BYZERO = 3'd1, S_ON = 3'd2, S_END = 3'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic               qneg_q, qneg_d;   // negate quotient at fix-up
  logic               rneg_q, rneg_d;   // negate remainder at fix-up
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Operand magnitudes at acceptance
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;

  // One restoring step on {rem, dvd}
  logic [WIDTH:0]   shifted, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, dvd_step, q_fix, r_fix;

  always_comb begin
    op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
    op1_mag  = op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    op2_mag  = op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // Borrow out of the (WIDTH+1)-bit subtract means the divisor did not fit
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH];
    rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], qbit};
    q_fix    = qneg_q ? (~dvd_step + WIDTH'(1)) : dvd_step;
    r_fix    = rneg_q ? (~rem_step + WIDTH'(1)) : rem_step;
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
`ifdef DIV_EARLY_EXIT_EN
            if (op1_mag < op2_mag) state_d = S_EARLY;
`endif
            cnt_d  = '0;
            rem_d  = '0;
            dvd_d  = op1_mag;
            dvs_d  = op2_mag;
            qneg_d = op1_neg ^ op2_neg;
            rneg_d = op1_neg;
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
      end
`ifdef DIV_EARLY_EXIT_EN
      // Quotient 0; remainder is the original dividend rebuilt from its magnitude
      S_EARLY: begin
        state_d  = S_END;
        result_d = {(rneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q), WIDTH'(0)};
      end
`endif
      S_ON: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_END;
          result_d = {r_fix, q_fix};
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
        end
      end
      default: begin
        state_d  = S_FREE;
        result_d = '0;
      end
    endcase

    // Annulment overrides start and last-step completion
    if (annul_i && state_q != S_FREE) begin
      state_d  = S_FREE;
      result_d = '0;
      cnt_d    = '0;
      rem_d    = '0;
      dvd_d    = '0;
    end

    ready_d = (state_d == S_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit (WIDTH=32): driver pushes expected
// result and ready cycle; monitor pops on each ready_o rising edge.
module tb_mips_div_unit;
  localparam int unsigned W = 32;
`ifdef DIV_EARLY_EXIT_EN
  localparam int SHORT = 1;
`else
  localparam int SHORT = 32;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   op1, op2;
  logic           start, annul;
  logic [2*W-1:0] result;
  logic           ready;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic ready_prev = 1'b0;

  mips_div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: compare each new result against the oldest expectation
  always @(posedge clk) begin
    #1;
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    ready_prev = ready;
  end

  // Issue one division; operands are scrambled after acceptance
  task automatic run_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] expv, input int lat, input int hold);
    int waited;
    @(posedge clk); #1;
    signed_div = sg; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back('{res: expv, cyc: cyc + 1 + lat});
    @(posedge clk); #1;
    op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0003; signed_div = ~sg;
    waited = 0;
    while (!ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'(1));
      start = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(ready), 64'(1));
      check("hold_result", result, expv);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", 64'(ready), 64'(0));
    check("drop_result", result, 64'(0));
  endtask

  // Start a long op, then abort with annul (kind=0) or rst (kind=1)
  task automatic abort_div(input int kind);
    int seen;
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (kind == 0) annul = 1'b1; else rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0; rst = 1'b0;
    check("abort_ready", 64'(ready), 64'(0));
    check("abort_result", result, 64'(0));
    seen = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    check("abort_no_ready", 64'(seen), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'(0));
    check("reset_result", result, 64'(0));
    rst = 1'b0;

    run_div(1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}, 32, 0);
    run_div(1'b1, 32'hFFFF_FFF9,  32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32, 0);
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 32, 0);
    run_div(1'b1, 32'h0000_0007,  32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 32, 0);
    run_div(1'b0, 32'hFFFF_FFFF,  32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF}, 32, 0);
    run_div(1'b1, 32'h0000_1234,  32'h0000_0000, 64'h0, 1, 0);
    run_div(1'b0, 32'h0000_1234,  32'h0000_0000, 64'h0, 1, 0);

    abort_div(0);
    run_div(1'b0, 32'd50, 32'd5, {32'h0000_0000, 32'h0000_000A}, 32, 0);
    abort_div(1);
    run_div(1'b0, 32'd50, 32'd5, {32'h0000_0000, 32'h0000_000A}, 32, 0);

    run_div(1'b0, 32'd3,         32'd10,        {32'h0000_0003, 32'h0000_0000}, SHORT, 0);
    run_div(1'b1, 32'hFFFF_FFFD, 32'd10,        {32'hFFFF_FFFD, 32'h0000_0000}, SHORT, 0);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, SHORT, 0);

    run_div(1'b0, 32'd1000, 32'd3, {32'h0000_0001, 32'h0000_014D}, 32, 5);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
